// File: rtl/execute_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage.
// master drives ID/EX fields and reads EX/MEM; slave is the EX stage.
interface execute_stage_if;
  logic        InValid;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic        RegDst;
  logic        RegWrite;
  logic        MemWrite;
  logic        MemToReg;
  logic        Branch;
  logic        BranchEqual;
  logic [5:0]  Op;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  Funct;
  logic [15:0] Imm;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Stall;
  logic        OutValid;
  logic [31:0] ALUResult;
  logic [31:0] StoreData;
  logic [4:0]  WriteReg;
  logic        OutRegWrite;
  logic        OutMemWrite;
  logic        OutMemToReg;
  logic        BranchTaken;

  modport master (
    output InValid, ALUOp, ALUSrc, RegDst,
    output RegWrite, MemWrite, MemToReg,
    output Branch, BranchEqual, Op, rt, rd,
    output shamt, Funct, Imm,
    output ReadData1, ReadData2,
    input  Stall, OutValid, ALUResult,
    input  StoreData, WriteReg, OutRegWrite,
    input  OutMemWrite, OutMemToReg, BranchTaken
  );

  modport slave (
    input  InValid, ALUOp, ALUSrc, RegDst,
    input  RegWrite, MemWrite, MemToReg,
    input  Branch, BranchEqual, Op, rt, rd,
    input  shamt, Funct, Imm,
    input  ReadData1, ReadData2,
    output Stall, OutValid, ALUResult,
    output StoreData, WriteReg, OutRegWrite,
    output OutMemWrite, OutMemToReg, BranchTaken
  );
endinterface

// File: rtl/execute_stage.sv
// EX stage: ALU/shift/compare/branch, iterative mult/div with HI/LO.
// Ports: Clock, Reset (sync, high), ex (slave: ID/EX in, EX/MEM + Stall out).
module execute_stage #(
  parameter int MD_CYCLES = 32
) (
  input  logic Clock,
  input  logic Reset,
  execute_stage_if.slave ex
);
  localparam int CW = $clog2(MD_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] count;
  logic [31:0] hi_q, lo_q;
  logic [31:0] w_hi, w_lo, md_b;
  logic md_div, neg_q, neg_r;

  logic is_md, accept, last, bubble;
  logic [31:0] immx, a, b, res;

  assign ex.Stall = (state == BUSY);
  assign is_md = ex.InValid && ex.ALUOp == 2'b10 &&
                 ex.Funct[5:2] == 4'b0110;
  assign accept = (state == IDLE) && is_md;
  assign last = (state == BUSY) && count == CW'(MD_CYCLES - 1);
  assign bubble = !ex.InValid || ex.Stall || accept;

  assign immx = (ex.Op == 6'h0C || ex.Op == 6'h0D)
              ? {16'h0, ex.Imm}
              : {{16{ex.Imm[15]}}, ex.Imm};
  assign a = ex.ReadData1;
  assign b = ex.ALUSrc ? immx : ex.ReadData2;

  always_comb begin
    res = '0;
    unique case (ex.ALUOp)
      2'b00: res = a + b;
      2'b01: res = a - b;
      2'b10: begin
        case (ex.Funct)
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = {31'h0, $signed(a) < $signed(b)};
          6'h2B: res = {31'h0, a < b};
          6'h00: res = b << ex.shamt;
          6'h02: res = b >> ex.shamt;
          6'h03: res = $unsigned($signed(b) >>> ex.shamt);
          6'h10: res = hi_q;
          6'h12: res = lo_q;
          default: res = '0;
        endcase
      end
      2'b11: begin
        case (ex.Op)
          6'h0C: res = a & b;
          6'h0D: res = a | b;
          6'h0A: res = {31'h0, $signed(a) < $signed(b)};
          6'h0F: res = {ex.Imm, 16'h0};
          default: res = '0;
        endcase
      end
      default: res = '0;
    endcase
  end

  // One iteration: shift-add multiply or restoring divide.
  logic [32:0] mul_sum;
  logic [32:0] div_r;
  logic [33:0] div_d;
  logic div_ok;
  logic [31:0] st_hi, st_lo, fin_hi, fin_lo;
  logic [63:0] prod_neg;

  always_comb begin
    mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, md_b} : 33'h0);
    div_r = {w_hi, w_lo[31]};
    div_d = {1'b0, div_r} - {2'b0, md_b};
    div_ok = !div_d[33];
    if (md_div) begin
      st_hi = div_ok ? div_d[31:0] : div_r[31:0];
      st_lo = {w_lo[30:0], div_ok};
    end else begin
      st_hi = mul_sum[32:1];
      st_lo = {mul_sum[0], w_lo[31:1]};
    end
    prod_neg = -{st_hi, st_lo};
    fin_hi = st_hi;
    fin_lo = st_lo;
    if (!md_div) begin
      if (neg_q) {fin_hi, fin_lo} = prod_neg;
    end else if (md_b != 32'h0) begin
      // Remainder follows the dividend's sign.
      if (neg_q) fin_lo = -st_lo;
      if (neg_r) fin_hi = -st_hi;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic sgn, sa, sb;
  assign sgn = !ex.Funct[0];
  assign sa = sgn && ex.ReadData1[31];
  assign sb = sgn && ex.ReadData2[31];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      hi_q <= '0;
      lo_q <= '0;
      w_hi <= '0;
      w_lo <= '0;
      md_b <= '0;
      md_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        count <= '0;
        w_hi <= '0;
        w_lo <= sa ? -ex.ReadData1 : ex.ReadData1;
        md_b <= sb ? -ex.ReadData2 : ex.ReadData2;
        md_div <= ex.Funct[1];
        neg_q <= sa ^ sb;
        neg_r <= sa;
      end else if (state == BUSY) begin
        count <= count + 1'b1;
        w_hi <= st_hi;
        w_lo <= st_lo;
        if (last) begin
          hi_q <= fin_hi;
          lo_q <= fin_lo;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || bubble) begin
      ex.OutValid <= 1'b0;
      ex.ALUResult <= '0;
      ex.StoreData <= '0;
      ex.WriteReg <= '0;
      ex.OutRegWrite <= 1'b0;
      ex.OutMemWrite <= 1'b0;
      ex.OutMemToReg <= 1'b0;
      ex.BranchTaken <= 1'b0;
    end else begin
      ex.OutValid <= 1'b1;
      ex.ALUResult <= res;
      ex.StoreData <= ex.ReadData2;
      ex.WriteReg <= ex.RegDst ? ex.rd : ex.rt;
      ex.OutRegWrite <= ex.RegWrite;
      ex.OutMemWrite <= ex.MemWrite;
      ex.OutMemToReg <= ex.MemToReg;
      ex.BranchTaken <= ex.Branch &&
        ((a == ex.ReadData2) == ex.BranchEqual);
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage.
// Hand-computed expectations for ALU, branch, mult/div and reset.
module tb_execute_stage;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int nvec = 0;
  int nerr = 0;

  execute_stage_if ex ();

  execute_stage #(.MD_CYCLES(32)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .ex(ex)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    ex.InValid = 0; ex.ALUOp = 0; ex.ALUSrc = 0;
    ex.RegDst = 0; ex.RegWrite = 0; ex.MemWrite = 0;
    ex.MemToReg = 0; ex.Branch = 0; ex.BranchEqual = 0;
    ex.Op = 0; ex.rt = 0; ex.rd = 0; ex.shamt = 0;
    ex.Funct = 0; ex.Imm = 0;
    ex.ReadData1 = 0; ex.ReadData2 = 0;
  endtask

  task automatic rtype(input logic [5:0] f,
                       input logic [31:0] ra,
                       input logic [31:0] rb,
                       input logic [4:0] sh);
    idle();
    ex.InValid = 1; ex.ALUOp = 2'b10; ex.Funct = f;
    ex.RegDst = 1; ex.RegWrite = 1; ex.rd = 5'd3;
    ex.ReadData1 = ra; ex.ReadData2 = rb; ex.shamt = sh;
  endtask

  task automatic itype(input logic [5:0] op,
                       input logic [31:0] ra,
                       input logic [15:0] im);
    idle();
    ex.InValid = 1; ex.ALUOp = 2'b11; ex.Op = op;
    ex.ALUSrc = 1; ex.RegWrite = 1; ex.rt = 5'd4;
    ex.ReadData1 = ra; ex.Imm = im;
  endtask

  // Launch a mult/div, hold mflo in ID/EX during the stall,
  // then read LO and HI.
  task automatic md(input string tag,
                    input logic [5:0] f,
                    input logic [31:0] ra,
                    input logic [31:0] rb,
                    input logic [31:0] elo,
                    input logic [31:0] ehi);
    int stalls;
    int bubbles;
    rtype(f, ra, rb, 0);
    step();
    stalls = 0;
    bubbles = (ex.OutValid == 0) ? 1 : 0;
    rtype(6'h12, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      if (!ex.Stall) break;
      stalls++;
      step();
      if (!ex.OutValid) bubbles++;
    end
    chk({tag, " stalls"}, stalls, 32);
    chk({tag, " bubbles"}, bubbles, 33);
    step();
    chk({tag, " lo"}, ex.ALUResult, elo);
    rtype(6'h10, 0, 0, 0);
    step();
    chk({tag, " hi"}, ex.ALUResult, ehi);
  endtask

  initial begin
    idle();
    Reset = 1;
    step();
    step();
    Reset = 0;
    step();
    chk("rst valid", {31'h0, ex.OutValid}, 0);
    chk("rst res", ex.ALUResult, 0);
    chk("rst wreg", {27'h0, ex.WriteReg}, 0);
    chk("rst regw", {31'h0, ex.OutRegWrite}, 0);
    chk("rst br", {31'h0, ex.BranchTaken}, 0);
    chk("rst stall", {31'h0, ex.Stall}, 0);

    idle();
    ex.InValid = 1; ex.ALUOp = 2'b10; ex.Funct = 6'h21;
    ex.ReadData1 = 32'hFFFF_FFFF; ex.ReadData2 = 2;
    ex.RegDst = 1; ex.rd = 5'd5; ex.RegWrite = 1;
    step();
    chk("addu res", ex.ALUResult, 1);
    chk("addu wreg", {27'h0, ex.WriteReg}, 5);
    chk("addu regw", {31'h0, ex.OutRegWrite}, 1);
    chk("addu valid", {31'h0, ex.OutValid}, 1);

    idle();
    ex.InValid = 1; ex.ALUSrc = 1; ex.ReadData1 = 32'h100;
    ex.Imm = 16'hFFFC; ex.rt = 5'd9; ex.RegWrite = 1;
    ex.MemToReg = 1;
    step();
    chk("lw addr", ex.ALUResult, 32'h0000_00FC);
    chk("lw wreg", {27'h0, ex.WriteReg}, 9);
    chk("lw m2r", {31'h0, ex.OutMemToReg}, 1);

    idle();
    ex.InValid = 1; ex.ALUOp = 2'b01; ex.Branch = 1;
    ex.BranchEqual = 1; ex.ReadData1 = 7; ex.ReadData2 = 7;
    step();
    chk("beq eq", {31'h0, ex.BranchTaken}, 1);
    ex.ReadData2 = 8;
    step();
    chk("beq ne", {31'h0, ex.BranchTaken}, 0);

    itype(6'h0C, 32'hFFFF_FFFF, 16'hFF00);
    step();
    chk("andi", ex.ALUResult, 32'h0000_FF00);
    itype(6'h0F, 0, 16'h1234);
    step();
    chk("lui", ex.ALUResult, 32'h1234_0000);
    itype(6'h0A, 32'hFFFF_FFF0, 16'hFFFF);
    step();
    chk("slti", ex.ALUResult, 1);
    rtype(6'h03, 0, 32'h8000_0000, 4);
    step();
    chk("sra", ex.ALUResult, 32'hF800_0000);
    rtype(6'h02, 0, 32'h8000_0000, 4);
    step();
    chk("srl", ex.ALUResult, 32'h0800_0000);
    rtype(6'h2A, 32'hFFFF_FFFF, 1, 0);
    step();
    chk("slt", ex.ALUResult, 1);
    rtype(6'h2B, 32'hFFFF_FFFF, 1, 0);
    step();
    chk("sltu", ex.ALUResult, 0);
    rtype(6'h27, 0, 0, 0);
    step();
    chk("nor", ex.ALUResult, 32'hFFFF_FFFF);
    rtype(6'h3F, 5, 6, 0);
    step();
    chk("unlisted", ex.ALUResult, 0);
    rtype(6'h21, 5, 6, 0);
    ex.InValid = 0;
    step();
    chk("inv regw", {31'h0, ex.OutRegWrite}, 0);

    md("mult", 6'h18, 32'hFFFF_FFFD, 5,
       32'hFFFF_FFF1, 32'hFFFF_FFFF);
    md("multu", 6'h19, 32'h8000_0000, 4,
       32'h0, 32'h2);
    md("divu0", 6'h1B, 7, 0, 32'hFFFF_FFFF, 7);
    md("div", 6'h1A, 32'hFFFF_FFF9, 2,
       32'hFFFF_FFFD, 32'hFFFF_FFFF);

    rtype(6'h19, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    step();
    idle();
    for (int i = 0; i < 10; i++) step();
    chk("mid stall", {31'h0, ex.Stall}, 1);
    Reset = 1;
    step();
    Reset = 0;
    chk("rst stall2", {31'h0, ex.Stall}, 0);
    rtype(6'h10, 0, 0, 0);
    step();
    chk("rst hi", ex.ALUResult, 0);
    rtype(6'h12, 0, 0, 0);
    step();
    chk("rst lo", ex.ALUResult, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
